// File: rtl/dct2d_row_col_sequencer.sv
// Drives one combinational 8-point 1-D DCT core through an 8x8 2-D DCT:
// a row pass into a transpose buffer, then a column pass to a valid/ready output.
module dct2d_row_col_sequencer #(
  parameter int IN_W      = 8,
  parameter int CORE_W    = 16,
  parameter int OUT_W     = 16,
  parameter int ROW_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*IN_W-1:0]   in_row,
  output logic [8*CORE_W-1:0] core_in,
  output logic                core_pass,
  input  logic [8*OUT_W-1:0]  core_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*OUT_W-1:0]  out_data,
  output logic [2:0]          out_col,
  output logic                out_last,
  output logic                busy,
  output logic                blk_done
);

  typedef enum logic [1:0] {IDLE, ROW, COL} state_t;

  // One extra bit of headroom so the clamp comparison never overflows.
  localparam int EXT_W = ((OUT_W > CORE_W) ? OUT_W : CORE_W) + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-CORE_W+1){1'b0}}, {(CORE_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-CORE_W+1){1'b1}}, {(CORE_W-1){1'b0}}};

  state_t            state, state_nxt;
  logic [2:0]        row_cnt, col_cnt;
  logic [CORE_W-1:0] tbuf [8][8];
  logic              accept, load;

  function automatic logic [CORE_W-1:0] row_scale(input logic [OUT_W-1:0] y);
    logic signed [EXT_W-1:0] v;
    v = $signed({{(EXT_W-OUT_W){y[OUT_W-1]}}, y}) >>> ROW_SHIFT;
    if (v > SAT_MAX)      row_scale = SAT_MAX[CORE_W-1:0];
    else if (v < SAT_MIN) row_scale = SAT_MIN[CORE_W-1:0];
    else                  row_scale = v[CORE_W-1:0];
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    core_pass = 1'b0;
    core_in   = '0;
    accept    = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE, ROW: begin
        in_ready = 1'b1;
        for (int k = 0; k < 8; k++)
          core_in[k*CORE_W +: CORE_W] = CORE_W'(in_row[k*IN_W +: IN_W]);
        accept = in_valid;
        if (accept) state_nxt = (row_cnt == 3'd7) ? COL : ROW;
      end
      COL: begin
        core_pass = 1'b1;
        for (int r = 0; r < 8; r++)
          core_in[r*CORE_W +: CORE_W] = tbuf[r][col_cnt];
        load = !out_valid || out_ready;
        if (load && col_cnt == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: the transpose buffer has no reset; its contents are rewritten before every column pass.
  always_ff @(posedge clk) begin
    if (accept)
      for (int k = 0; k < 8; k++)
        tbuf[row_cnt][k] <= row_scale(core_out[k*OUT_W +: OUT_W]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      blk_done  <= 1'b0;
    end else begin
      blk_done <= out_valid && out_ready && out_last;
      if (accept) row_cnt <= row_cnt + 3'd1;
      // A load in the same cycle as a handshake refills the register with no bubble.
      if (load) begin
        out_data  <= core_out;
        out_col   <= col_cnt;
        out_last  <= (col_cnt == 3'd7);
        out_valid <= 1'b1;
        col_cnt   <= col_cnt + 3'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dct2d_row_col_sequencer.sv
// Randomised bench for dct2d_row_col_sequencer: identity-core instance plus a
// ROW_SHIFT=3 instance fed by a constant-output row core for the saturation path.
module tb_dct2d_row_col_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, out_ready, sel;
  logic [63:0]  in_row;
  logic [15:0]  cval;
  bit           rdy_mode;

  logic         in_ready_a, core_pass_a, out_valid_a, out_last_a, busy_a, blk_done_a;
  logic [127:0] core_in_a, core_out_a, out_data_a;
  logic [2:0]   out_col_a;
  logic         in_ready_b, core_pass_b, out_valid_b, out_last_b, busy_b, blk_done_b;
  logic [127:0] core_in_b, core_out_b, out_data_b;
  logic [2:0]   out_col_b;
  logic         in_valid_a, in_valid_b;

  assign in_valid_a = in_valid & ~sel;
  assign in_valid_b = in_valid & sel;
  assign core_out_a = core_in_a;
  assign core_out_b = core_pass_b ? core_in_b : {8{cval}};

  dct2d_row_col_sequencer #(.IN_W(8), .CORE_W(16), .OUT_W(16), .ROW_SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_row(in_row),
    .core_in(core_in_a), .core_pass(core_pass_a), .core_out(core_out_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_col(out_col_a), .out_last(out_last_a), .busy(busy_a), .blk_done(blk_done_a));

  dct2d_row_col_sequencer #(.IN_W(8), .CORE_W(16), .OUT_W(16), .ROW_SHIFT(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_row(in_row),
    .core_in(core_in_b), .core_pass(core_pass_b), .core_out(core_out_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_col(out_col_b), .out_last(out_last_b), .busy(busy_b), .blk_done(blk_done_b));

  logic         m_in_ready, m_pass, m_valid, m_last, m_busy, m_done;
  logic [127:0] m_data;
  logic [2:0]   m_col;
  assign m_in_ready = sel ? in_ready_b  : in_ready_a;
  assign m_pass     = sel ? core_pass_b : core_pass_a;
  assign m_valid    = sel ? out_valid_b : out_valid_a;
  assign m_last     = sel ? out_last_b  : out_last_a;
  assign m_busy     = sel ? busy_b      : busy_a;
  assign m_done     = sel ? blk_done_b  : blk_done_a;
  assign m_data     = sel ? out_data_b  : out_data_a;
  assign m_col      = sel ? out_col_b   : out_col_a;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic [2:0]   col;
    logic         last;
  } beat_t;
  typedef logic [7:0] blk_t [8][8];

  beat_t exp_q[$];

  // Reference: row core result, divided by 2^shift (floor), clamped to 16 bits;
  // the identity column core then emits the transposed buffer.
  function automatic logic [15:0] model_elem(input logic [7:0] p);
    int y;
    if (sel) y = int'($signed(cval)) >>> 3;
    else     y = int'(p);
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y[15:0];
  endfunction

  function automatic void push_block(input blk_t b);
    beat_t e;
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) e.data[r*16 +: 16] = model_elem(b[r][c]);
      e.col  = 3'(c);
      e.last = (c == 7);
      exp_q.push_back(e);
    end
  endfunction

  // Output monitor: sampled on the falling edge, away from the active edge.
  logic         prev_hs, prev_last, prev_stall, prev_lastv;
  logic [127:0] prev_data, last_data;
  logic [2:0]   prev_col;
  always @(negedge clk) begin
    if (rst) begin
      prev_hs = 1'b0; prev_last = 1'b0; prev_stall = 1'b0;
    end else begin
      beat_t e;
      check("blk_done", m_done, prev_hs && prev_last);
      if (prev_stall) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, prev_data);
        check("hold_col", m_col, prev_col);
        check("hold_last", m_last, prev_lastv);
      end
      if (prev_hs && !prev_last) check("no_bubble", m_valid, 1'b1);
      if (m_valid && out_ready) begin
        check("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_col", m_col, e.col);
          check("beat_last", m_last, e.last);
        end
        last_data = m_data;
      end
      prev_hs    = m_valid && out_ready;
      prev_last  = m_last;
      prev_stall = m_valid && !out_ready;
      prev_data  = m_data;
      prev_col   = m_col;
      prev_lastv = m_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_row(input logic [63:0] row, output int waits);
    bit acc;
    in_valid = 1'b1;
    in_row   = row;
    waits    = 0;
    forever begin
      acc = m_in_ready;
      @(posedge clk); #1;
      if (acc) break;
      waits++;
      if (waits > 300) begin
        check("accept_timeout", 128'(waits), 128'd0);
        break;
      end
    end
  endtask

  task automatic send_block(input blk_t b, input int nrows, input bit keep, input bit gaps,
                            input bit lat, output int first_wait);
    logic [63:0] row;
    int w;
    first_wait = 0;
    for (int r = 0; r < nrows; r++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int k = 0; k < 8; k++) row[k*8 +: 8] = b[r][k];
      send_row(row, w);
      if (r == 0) first_wait = w;
    end
    if (nrows == 8) push_block(b);
    if (!keep) in_valid = 1'b0;
    if (lat) begin
      check("lat_pre_valid", m_valid, 1'b0);
      @(posedge clk); #1;
      check("lat_valid", m_valid, 1'b1);
      check("lat_col", m_col, 3'd0);
      check("col_pass", m_pass, 1'b1);
      check("busy_col", m_busy, 1'b1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
    check("drain_valid", m_valid, 1'b0);
  endtask

  task automatic stall_at(input bit want_last, input logic [2:0] col, input int len);
    int n = 0;
    while (!(m_valid && (want_last ? m_last : (m_col == col))) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_found", n < 200, 1'b1);
    out_ready = 1'b0;
    repeat (len) begin @(posedge clk); #1; end
    out_ready = 1'b1;
  endtask

  function automatic void rand_block(output blk_t b);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) b[r][k] = 8'($urandom);
  endfunction

  blk_t ramp, rb1, rb2;
  int   w, w2;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_row = '0; out_ready = 1'b1;
    sel = 1'b0; cval = '0; rdy_mode = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) ramp[r][k] = 8'(8*r + k);

    // Reset state of both instances
    repeat (2) begin @(posedge clk); #1; end
    check("rst_valid_a", out_valid_a, 1'b0);
    check("rst_ready_a", in_ready_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_done_a", blk_done_a, 1'b0);
    check("rst_data_a", {out_data_a, out_col_a, out_last_a}, '0);
    check("rst_pass_a", core_pass_a, 1'b0);
    check("rst_valid_b", out_valid_b, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_data_b", {out_data_b, out_col_b, out_last_b}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp block, no stalls
    send_block(ramp, 8, 1'b0, 1'b0, 1'b1, w);
    drain();
    check("idle_busy", m_busy, 1'b0);

    // Ramp block with a 5-cycle stall on column 2
    fork
      send_block(ramp, 8, 1'b0, 1'b0, 1'b1, w);
      stall_at(1'b0, 3'd2, 5);
    join
    drain();

    // in_valid held through the column pass; last beat of block 1 stalled
    rand_block(rb1);
    rand_block(rb2);
    fork
      begin
        send_block(rb1, 8, 1'b1, 1'b0, 1'b0, w);
        send_block(rb2, 8, 1'b0, 1'b0, 1'b0, w2);
        check("in_ready_low_cycles", 128'(w2), 128'd8);
      end
      stall_at(1'b1, 3'd7, 10);
    join
    drain();

    // Abort after 3 rows, then a fresh block
    rand_block(rb1);
    send_block(rb1, 3, 1'b0, 1'b0, 1'b0, w);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("abort_valid", m_valid, 1'b0);
    check("abort_busy", m_busy, 1'b0);
    check("abort_ready", m_in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    send_block(ramp, 8, 1'b0, 1'b0, 1'b1, w);
    drain();

    // Random blocks with random input gaps and random out_ready
    rdy_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_block(rb1);
      send_block(rb1, 8, 1'b0, 1'b1, 1'b0, w);
    end
    drain();
    rdy_mode = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Shifted instance: negative full-scale and positive full-scale row results
    sel = 1'b1;
    cval = 16'h8000;
    rand_block(rb1);
    send_block(rb1, 8, 1'b0, 1'b0, 1'b1, w);
    drain();
    check("shift_min", last_data[15:0], 16'hF000);
    cval = 16'h7FFF;
    send_block(rb1, 8, 1'b0, 1'b0, 1'b1, w);
    drain();
    check("shift_max", last_data[127:112], 16'h0FFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
